simple_cpu: RTL and testbench

Minimal 8-bit accumulator processor with a hard-wired 16-word program ROM, a 16-byte data RAM and a single registered output port. It executes one instruction per clock from reset and exposes program output on `result` through an explicit OUT instruction. It is a self-contained top-level demo core with no external bus.

---
 rtl/simple_cpu.sv | 149 ++++++++++++++
 tb/tb_simple_cpu.sv | 124 ++++++++++++
 2 files changed

// File: rtl/simple_cpu.sv
`default_nettype none
// ============================================================================
// Module   : simple_cpu
// Purpose  : Minimal 8-bit accumulator processor. Executes one instruction
//            per clock from a hard-wired 16-word ROM, with a 16-byte data
//            RAM and a registered output port loaded only by OUT.
// Ports    : clk    - single clock, all state updates on rising edge
//            rst    - synchronous active-low reset (clears all state)
//            result - registered 8-bit program output
// Revision : 1.0 - initial release
// ============================================================================
module simple_cpu (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] result
);

   // Opcodes
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADDI = 4'h2;
   localparam logic [3:0] OP_SUBI = 4'h3;
   localparam logic [3:0] OP_LDA  = 4'h4;
   localparam logic [3:0] OP_STA  = 4'h5;
   localparam logic [3:0] OP_ADDM = 4'h6;
   localparam logic [3:0] OP_SUBM = 4'h7;
   localparam logic [3:0] OP_AND  = 4'h8;
   localparam logic [3:0] OP_OR   = 4'h9;
   localparam logic [3:0] OP_XOR  = 4'hA;
   localparam logic [3:0] OP_SHL  = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_JZ   = 4'hD;
   localparam logic [3:0] OP_OUT  = 4'hE;
   localparam logic [3:0] OP_HLT  = 4'hF;

   // Architectural state
   logic [3:0] pc_q,     pc_d;
   logic [7:0] a_q,      a_d;
   logic       z_q,      z_d;
   logic       c_q,      c_d;
   logic       halt_q,   halt_d;
   logic [7:0] result_q, result_d;
   logic [7:0] mem_q [16];

   // Decode
   logic [7:0] instr;
   logic [3:0] opcode;
   logic [3:0] k;
   logic [7:0] mem_rd;
   logic       mem_we;
   logic [8:0] sum_imm;
   logic [8:0] dif_imm;
   logic [8:0] sum_mem;
   logic [8:0] dif_mem;

   // Program ROM, fetched combinationally from the current PC
   always_comb begin
      instr = 8'h00;
      case (pc_q)
         4'd0:    instr = 8'h15; // LDI 5
         4'd1:    instr = 8'h23; // ADDI 3
         4'd2:    instr = 8'hE0; // OUT
         4'd3:    instr = 8'h50; // STA 0
         4'd4:    instr = 8'h60; // ADDM 0
         4'd5:    instr = 8'hE0; // OUT
         4'd6:    instr = 8'h31; // SUBI 1
         4'd7:    instr = 8'hE0; // OUT
         4'd8:    instr = 8'hF0; // HLT
         default: instr = 8'h00;
      endcase
   end

   assign opcode = instr[7:4];
   assign k      = instr[3:0];
   assign mem_rd = mem_q[k];

   // 9-bit arithmetic: bit 8 is carry-out on add, borrow on subtract
   assign sum_imm = {1'b0, a_q} + {5'b0, k};
   assign dif_imm = {1'b0, a_q} - {5'b0, k};
   assign sum_mem = {1'b0, a_q} + {1'b0, mem_rd};
   assign dif_mem = {1'b0, a_q} - {1'b0, mem_rd};

   // Execute: next-state for every register
   always_comb begin
      pc_d     = pc_q + 4'd1;
      a_d      = a_q;
      z_d      = z_q;
      c_d      = c_q;
      halt_d   = halt_q;
      result_d = result_q;
      mem_we   = 1'b0;

      case (opcode)
         OP_NOP:  ;
         OP_LDI:  a_d = {4'b0000, k};
         OP_ADDI: begin a_d = sum_imm[7:0]; c_d = sum_imm[8]; end
         OP_SUBI: begin a_d = dif_imm[7:0]; c_d = dif_imm[8]; end
         OP_LDA:  a_d = mem_rd;
         OP_STA:  mem_we = 1'b1;
         OP_ADDM: begin a_d = sum_mem[7:0]; c_d = sum_mem[8]; end
         OP_SUBM: begin a_d = dif_mem[7:0]; c_d = dif_mem[8]; end
         OP_AND:  begin a_d = a_q & mem_rd; c_d = 1'b0; end
         OP_OR:   begin a_d = a_q | mem_rd; c_d = 1'b0; end
         OP_XOR:  begin a_d = a_q ^ mem_rd; c_d = 1'b0; end
         OP_SHL:  begin a_d = {a_q[6:0], 1'b0}; c_d = a_q[7]; end
         OP_JMP:  pc_d = k;
         OP_JZ:   if (z_q) pc_d = k;
         OP_OUT:  result_d = a_q;
         OP_HLT:  begin halt_d = 1'b1; pc_d = pc_q; end // PC parks on HLT
         default: ;
      endcase

      // Z tracks the new accumulator only for opcodes that write A
      case (opcode)
         OP_LDI, OP_ADDI, OP_SUBI, OP_LDA, OP_ADDM, OP_SUBM,
         OP_AND, OP_OR, OP_XOR, OP_SHL: z_d = (a_d == 8'h00);
         default: ;
      endcase
   end

   // State registers; reset wins over everything, halt freezes everything
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q     <= 4'd0;
         a_q      <= 8'h00;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         halt_q   <= 1'b0;
         result_q <= 8'h00;
         for (int i = 0; i < 16; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (!halt_q) begin
         pc_q     <= pc_d;
         a_q      <= a_d;
         z_q      <= z_d;
         c_q      <= c_d;
         halt_q   <= halt_d;
         result_q <= result_d;
         if (mem_we) begin
            mem_q[k] <= a_q;
         end
      end
   end

   assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_simple_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_cpu
// Purpose  : Directed self-checking bench for simple_cpu. Runs the built-in
//            program through power-up reset, post-halt idling, a mid-run
//            reset and a reset while halted, checking result and internal
//            state against hand-computed timeline values.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_simple_cpu;

   logic       clk;
   logic       rst;
   logic [7:0] result;

   int tests_run;
   int tests_failed;

   simple_cpu dut (
      .clk    (clk),
      .rst    (rst),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected result after edge n following reset release
   function automatic logic [7:0] exp_result(input int n);
      if (n < 3)      return 8'd0;
      else if (n < 6) return 8'd8;
      else if (n < 8) return 8'd16;
      else            return 8'd15;
   endfunction

   // One rising edge, then sample on the following falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset(input int edges);
      rst = 1'b0;
      for (int i = 0; i < edges; i++) step();
      rst = 1'b1;
      check("rst_result", {24'd0, result}, 32'd0);
      check("rst_pc",     {28'd0, dut.pc_q}, 32'd0);
      check("rst_halt",   {31'd0, dut.halt_q}, 32'd0);
      check("rst_mem0",   {24'd0, dut.mem_q[0]}, 32'd0);
      check("rst_a",      {24'd0, dut.a_q}, 32'd0);
   endtask

   // Run edges 1..last after reset release, checking the timeline
   task automatic run_program(input int last);
      for (int n = 1; n <= last; n++) begin
         step();
         check($sformatf("result_e%0d", n), {24'd0, result},
               {24'd0, exp_result(n)});
         if (n == 4) check("mem0_e4", {24'd0, dut.mem_q[0]}, 32'd8);
         if (n == 5) check("a_e5",    {24'd0, dut.a_q}, 32'd16);
         if (n == 7) begin
            check("a_e7", {24'd0, dut.a_q}, 32'd15);
            check("c_e7", {31'd0, dut.c_q}, 32'd0);
            check("z_e7", {31'd0, dut.z_q}, 32'd0);
         end
         if (n < 9) check($sformatf("pc_e%0d", n), {28'd0, dut.pc_q}, n);
         if (n >= 9) begin
            check($sformatf("pc_halt_e%0d", n), {28'd0, dut.pc_q}, 32'd8);
            check($sformatf("halt_e%0d", n), {31'd0, dut.halt_q}, 32'd1);
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b0;

      // Power-up reset for two edges, then full program
      apply_reset(2);
      run_program(12);

      // Idle while halted: nothing may move
      for (int i = 0; i < 20; i++) begin
         step();
         check("idle_result", {24'd0, result}, 32'd15);
         check("idle_pc",     {28'd0, dut.pc_q}, 32'd8);
         check("idle_a",      {24'd0, dut.a_q}, 32'd15);
         check("idle_mem0",   {24'd0, dut.mem_q[0]}, 32'd8);
      end

      // Reset while halted, program replays
      apply_reset(1);
      run_program(12);

      // Mid-run reset right after result reaches 16
      apply_reset(1);
      run_program(6);
      apply_reset(1);
      run_program(12);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Absolute watchdog so the run always terminates
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
